board_buffer: RTL and testbench
===============================

Name: board_buffer

Overview:
- Tile-value store that sits directly upstream of the board renderer.
- Holds the 4x4 board as 5-bit exponents in two copies: a shadow copy written by game logic, and a live copy read by the display.
- Shadow-to-live transfer happens only at frame start, after game logic commits a move, so a frame never shows a half-applied move.
- Returns the 17-bit tile value for the row/col the renderer is currently drawing.

Parameters:
- EXP_W, 5, exponent width per tile; 0 = empty tile, 1..16 = tile value 2^exp.
- DATA_W, 17, width of the decoded tile value on data.
- MAX_EXP, 16, largest legal exponent; writes above it are rejected.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz.
- CPU_RESETN  in  1  synchronous, active-low reset.
- wr_en  in  1  shadow write strobe; accepted only when wr_ready=1.
- wr_row  in  2  shadow write row index.
- wr_col  in  2  shadow write column index.
- wr_exp  in  EXP_W  exponent to write.
- wr_ready  out  1  high when shadow writes are accepted.
- wr_err  out  1  one-cycle pulse when a write is rejected (illegal exponent, or wr_en while not ready).
- commit  in  1  one-cycle pulse: shadow holds a complete move.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- pending  out  1  commit is latched and waiting for frame_start.
- row  in  2  renderer row being drawn.
- col  in  2  renderer column being drawn.
- draw  in  1  renderer is drawing a tile/board pixel.
- data  out  DATA_W  registered tile value for (row, col).

Behaviour:
- Reset (CPU_RESETN=0 at a clock edge):
  - Both copies cleared to exponent 0.
  - State = IDLE; pending=0, wr_ready=1, wr_err=0, data=0.
  - A reset in the middle of a copy aborts the copy; no partial state survives.
- Index: tile index = row*4 + col, range 0..15.
- Shadow write (wr_en=1, wr_ready=1, wr_exp<=MAX_EXP): shadow[wr_row*4+wr_col] <= wr_exp on that edge.
- Rejected write: if wr_exp>MAX_EXP, or wr_en=1 while wr_ready=0:
  - Shadow is unchanged.
  - wr_err=1 on the next cycle only.
- State machine:
  - IDLE: wr_ready=1. If frame_start=1 and pending=1, go to COPY with copy_idx=0 and clear pending. If frame_start=1 and pending=0, stay in IDLE.
  - COPY: wr_ready=0. Each clock, live[copy_idx] <= shadow[copy_idx], then copy_idx increments. After the cycle that copies index 15, return to IDLE. COPY lasts exactly 16 cycles; wr_ready returns to 1 on the 17th cycle after frame_start.
- pending:
  - Set by commit in any state.
  - Cleared only when COPY is entered.
  - commit and frame_start in the same cycle while IDLE with pending=0: pending=1 and no copy starts; the copy waits for the next frame_start.
  - commit during COPY: pending=1 again, serviced at the next frame_start.
- Write and commit in the same cycle: the write lands first, so that commit includes it.
- frame_start during COPY: ignored.
- data:
  - Registered, 1-cycle latency from row/col/draw.
  - data <= (draw=0 or live exp=0) ? 0 : 1 << exp.
  - exp=16 gives 65536 (bit 16 set).
  - The renderer's pixel strobe is 1 in 4 clocks, so the 1-cycle lag is invisible.
- Live-copy reads during COPY: tiles already copied return the new value. A mixed frame is impossible because COPY runs entirely inside vertical blank.

Optional Feature:
- Macro: BOARD_TEST_PATTERN_EN.
- Defined:
  - Adds input test_mode (1 bit).
  - When test_mode=1, data <= draw ? 1 << (row*4+col+1) : 0, regardless of the live copy. Tile (0,0)=2 and tile (3,3)=65536.
  - Shadow/live/commit logic continues to run unchanged.
- Undefined: no test_mode port; data always comes from the live copy.

Test Plan:
- Reset, then read all 16 (row, col) with draw=1 -> data=0 for every tile; wr_ready=1, pending=0.
- Write exp=1 to (0,0) and exp=11 to (2,3), commit, frame_start -> wr_ready=0 for exactly 16 cycles, pending clears; afterwards (0,0) reads 2, (2,3) reads 2048, draw=0 reads 0.
- Write exp=5 to (1,1) and commit, no frame_start for 1000 cycles -> (1,1) still reads its old value and pending=1; after frame_start + 16 cycles -> reads 32.
- wr_en with wr_exp=17, and wr_en during COPY -> shadow unchanged, wr_err one-cycle pulse for each.
- commit during COPY -> pending=1 after COPY; next frame_start starts a second 16-cycle copy. Assert CPU_RESETN=0 at copy_idx=7 -> all tiles read 0 and state=IDLE.
- With BOARD_TEST_PATTERN_EN and test_mode=1 -> (0,0)=2, (1,2)=128, (3,3)=65536, and these values hold across commits.

Source files
------------

// File: rtl/board_buffer.sv
// Double-buffered 4x4 tile-exponent store feeding the board renderer.
// Optional BOARD_TEST_PATTERN_EN adds a test_mode input that overrides data with a fixed pattern.
module board_buffer #(
  parameter int EXP_W   = 5,
  parameter int DATA_W  = 17,
  parameter int MAX_EXP = 16
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
`ifdef BOARD_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  input  logic              wr_en,
  input  logic [1:0]        wr_row,
  input  logic [1:0]        wr_col,
  input  logic [EXP_W-1:0]  wr_exp,
  output logic              wr_ready,
  output logic              wr_err,
  input  logic              commit,
  input  logic              frame_start,
  output logic              pending,
  input  logic [1:0]        row,
  input  logic [1:0]        col,
  input  logic              draw,
  output logic [DATA_W-1:0] data
);

  localparam logic [EXP_W-1:0] MAX_EXP_V = EXP_W'(MAX_EXP);

  typedef enum logic {S_IDLE, S_COPY} state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic              w_ready;
  logic              w_startCopy;

  logic [EXP_W-1:0]  r_shadow [16];
  logic [EXP_W-1:0]  r_live   [16];
  logic [3:0]        r_copyIdx;
  logic              r_pending;
  logic              r_wrErr;
  logic [DATA_W-1:0] r_data;

  logic [3:0]        w_wrIdx;
  logic [3:0]        w_rdIdx;
  logic              w_wrAccept;
  logic              w_wrReject;
  logic [EXP_W-1:0]  w_liveExp;
  logic [DATA_W-1:0] w_liveVal;
  logic [DATA_W-1:0] w_dataNext;

  assign w_wrIdx    = {wr_row, wr_col};
  assign w_rdIdx    = {row, col};
  assign w_wrAccept = wr_en && w_ready && (wr_exp <= MAX_EXP_V);
  assign w_wrReject = wr_en && (!w_ready || (wr_exp > MAX_EXP_V));

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) r_state <= S_IDLE;
    else             r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_ready     = 1'b0;
    w_startCopy = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (frame_start && r_pending) begin
          w_stateNext = S_COPY;
          w_startCopy = 1'b1;
        end
      end
      S_COPY: begin
        if (r_copyIdx == 4'd15) w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Shadow is only written while idle, so it is stable for the whole copy.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < 16; i++) r_shadow[i] <= '0;
    end else if (w_wrAccept) begin
      r_shadow[w_wrIdx] <= wr_exp;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < 16; i++) r_live[i] <= '0;
      r_copyIdx <= '0;
    end else if (w_startCopy) begin
      r_copyIdx <= '0;
    end else if (r_state == S_COPY) begin
      r_live[r_copyIdx] <= r_shadow[r_copyIdx];
      r_copyIdx         <= r_copyIdx + 4'd1;
    end
  end

  // A commit arriving on the same edge the copy starts must not be lost.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_pending <= 1'b0;
      r_wrErr   <= 1'b0;
    end else begin
      r_wrErr <= w_wrReject;
      if (commit)           r_pending <= 1'b1;
      else if (w_startCopy) r_pending <= 1'b0;
    end
  end

  assign w_liveExp = r_live[w_rdIdx];
  assign w_liveVal = (draw && (w_liveExp != '0)) ? (DATA_W'(1) << w_liveExp) : '0;

`ifdef BOARD_TEST_PATTERN_EN
  logic [4:0]        w_tpShift;
  logic [DATA_W-1:0] w_tpVal;
  assign w_tpShift  = {1'b0, w_rdIdx} + 5'd1;
  assign w_tpVal    = draw ? (DATA_W'(1) << w_tpShift) : '0;
  assign w_dataNext = test_mode ? w_tpVal : w_liveVal;
`else
  assign w_dataNext = w_liveVal;
`endif

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) r_data <= '0;
    else             r_data <= w_dataNext;
  end

  assign wr_ready = w_ready;
  assign wr_err   = r_wrErr;
  assign pending  = r_pending;
  assign data     = r_data;

endmodule

// File: tb/tb_board_buffer.sv
// Directed self-checking bench for board_buffer: writes, commits, frame-start copies,
// rejected writes and reset during a copy, all against hand-computed expectations.
module tb_board_buffer;

  logic        CLK100MHZ = 1'b0;
  logic        CPU_RESETN = 1'b0;
  logic        test_mode = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_row = '0;
  logic [1:0]  wr_col = '0;
  logic [4:0]  wr_exp = '0;
  logic        wr_ready;
  logic        wr_err;
  logic        commit = 1'b0;
  logic        frame_start = 1'b0;
  logic        pending;
  logic [1:0]  row = '0;
  logic [1:0]  col = '0;
  logic        draw = 1'b0;
  logic [16:0] data;

  int checks = 0;
  int failures = 0;
  int lowCycles;

  always #5 CLK100MHZ = ~CLK100MHZ;

  board_buffer dut (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
`ifdef BOARD_TEST_PATTERN_EN
    .test_mode  (test_mode),
`endif
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_exp     (wr_exp),
    .wr_ready   (wr_ready),
    .wr_err     (wr_err),
    .commit     (commit),
    .frame_start(frame_start),
    .pending    (pending),
    .row        (row),
    .col        (col),
    .draw       (draw),
    .data       (data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One write attempt, optionally with commit on the same edge.
  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] c, input logic [4:0] e, input logic withCommit);
    wr_en  = 1'b1;
    wr_row = r;
    wr_col = c;
    wr_exp = e;
    commit = withCommit;
    @(negedge CLK100MHZ);
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  task automatic checkTile(input string tag, input logic [1:0] r, input logic [1:0] c, input logic d, input logic [31:0] expected);
    row  = r;
    col  = c;
    draw = d;
    @(negedge CLK100MHZ);
    checkOutput(tag, 32'(data), expected);
    draw = 1'b0;
  endtask

  task automatic pulseCommit();
    commit = 1'b1;
    @(negedge CLK100MHZ);
    commit = 1'b0;
  endtask

  task automatic pulseFrame();
    frame_start = 1'b1;
    @(negedge CLK100MHZ);
    frame_start = 1'b0;
  endtask

  // Counts remaining busy cycles; a stuck copy shows up as a failed ready check.
  task automatic waitCopyDone(output int n);
    n = 0;
    for (int i = 0; i < 64 && wr_ready == 1'b0; i++) begin
      n++;
      @(negedge CLK100MHZ);
    end
    checkOutput("readyAfterCopy", 32'(wr_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    checkOutput("rstReady", 32'(wr_ready), 32'd1);
    checkOutput("rstPending", 32'(pending), 32'd0);
    checkOutput("rstErr", 32'(wr_err), 32'd0);
    checkOutput("rstData", 32'(data), 32'd0);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] idx;
      idx = 4'(i);
      checkTile($sformatf("rstTile%0d", i), idx[3:2], idx[1:0], 1'b1, 32'd0);
    end

    applyStimulus(2'd0, 2'd0, 5'd1, 1'b0);
    checkOutput("errLegal", 32'(wr_err), 32'd0);
    applyStimulus(2'd2, 2'd3, 5'd11, 1'b0);
    pulseCommit();
    checkOutput("pendAfterCommit", 32'(pending), 32'd1);
    pulseFrame();
    checkOutput("readyInCopy", 32'(wr_ready), 32'd0);
    checkOutput("pendClearInCopy", 32'(pending), 32'd0);
    waitCopyDone(lowCycles);
    checkOutput("copyLen1", 32'(lowCycles), 32'd16);
    checkTile("tile00", 2'd0, 2'd0, 1'b1, 32'd2);
    checkTile("tile23", 2'd2, 2'd3, 1'b1, 32'd2048);
    checkTile("tile23NoDraw", 2'd2, 2'd3, 1'b0, 32'd0);
    checkTile("tile11Empty", 2'd1, 2'd1, 1'b1, 32'd0);

    applyStimulus(2'd1, 2'd1, 5'd5, 1'b0);
    commit = 1'b1;
    frame_start = 1'b1;
    @(negedge CLK100MHZ);
    commit = 1'b0;
    frame_start = 1'b0;
    checkOutput("sameCyclePend", 32'(pending), 32'd1);
    checkOutput("sameCycleNoCopy", 32'(wr_ready), 32'd1);
    repeat (1000) @(negedge CLK100MHZ);
    checkTile("tile11Held", 2'd1, 2'd1, 1'b1, 32'd0);
    checkOutput("pendHeld", 32'(pending), 32'd1);
    pulseFrame();
    waitCopyDone(lowCycles);
    checkOutput("copyLen2", 32'(lowCycles), 32'd16);
    checkTile("tile11New", 2'd1, 2'd1, 1'b1, 32'd32);
    checkTile("tile00Kept", 2'd0, 2'd0, 1'b1, 32'd2);

    applyStimulus(2'd2, 2'd0, 5'd2, 1'b1);
    checkOutput("pendWriteCommit", 32'(pending), 32'd1);
    pulseFrame();
    waitCopyDone(lowCycles);
    checkTile("tile20WriteCommit", 2'd2, 2'd0, 1'b1, 32'd4);

    applyStimulus(2'd3, 2'd0, 5'd17, 1'b0);
    checkOutput("errIllegal", 32'(wr_err), 32'd1);
    @(negedge CLK100MHZ);
    checkOutput("errIllegalPulse", 32'(wr_err), 32'd0);
    applyStimulus(2'd3, 2'd3, 5'd16, 1'b0);
    pulseCommit();
    pulseFrame();
    applyStimulus(2'd3, 2'd2, 5'd3, 1'b0);
    checkOutput("errBusy", 32'(wr_err), 32'd1);
    pulseCommit();
    checkOutput("errBusyPulse", 32'(wr_err), 32'd0);
    waitCopyDone(lowCycles);
    checkOutput("pendAfterCopyCommit", 32'(pending), 32'd1);
    checkTile("tile33Max", 2'd3, 2'd3, 1'b1, 32'd65536);
    checkTile("tile32Rejected", 2'd3, 2'd2, 1'b1, 32'd0);
    checkTile("tile30Rejected", 2'd3, 2'd0, 1'b1, 32'd0);

    pulseFrame();
    checkOutput("readyCopy2", 32'(wr_ready), 32'd0);
    checkOutput("pendCopy2", 32'(pending), 32'd0);
    repeat (7) @(negedge CLK100MHZ);
    CPU_RESETN = 1'b0;
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    checkOutput("midRstReady", 32'(wr_ready), 32'd1);
    checkOutput("midRstPending", 32'(pending), 32'd0);
    checkOutput("midRstData", 32'(data), 32'd0);
    checkTile("midRst00", 2'd0, 2'd0, 1'b1, 32'd0);
    checkTile("midRst11", 2'd1, 2'd1, 1'b1, 32'd0);
    checkTile("midRst23", 2'd2, 2'd3, 1'b1, 32'd0);
    checkTile("midRst33", 2'd3, 2'd3, 1'b1, 32'd0);
    pulseCommit();
    pulseFrame();
    waitCopyDone(lowCycles);
    checkOutput("copyLen3", 32'(lowCycles), 32'd16);
    checkTile("shadowClr00", 2'd0, 2'd0, 1'b1, 32'd0);
    checkTile("shadowClr33", 2'd3, 2'd3, 1'b1, 32'd0);

`ifdef BOARD_TEST_PATTERN_EN
    test_mode = 1'b1;
    checkTile("tp00", 2'd0, 2'd0, 1'b1, 32'd2);
    checkTile("tp12", 2'd1, 2'd2, 1'b1, 32'd128);
    checkTile("tp33", 2'd3, 2'd3, 1'b1, 32'd65536);
    checkTile("tpNoDraw", 2'd3, 2'd3, 1'b0, 32'd0);
    applyStimulus(2'd0, 2'd0, 5'd3, 1'b1);
    pulseFrame();
    waitCopyDone(lowCycles);
    checkTile("tp00AfterCommit", 2'd0, 2'd0, 1'b1, 32'd2);
    checkTile("tp33AfterCommit", 2'd3, 2'd3, 1'b1, 32'd65536);
    test_mode = 1'b0;
    checkTile("tpOffLive00", 2'd0, 2'd0, 1'b1, 32'd8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
